// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids,
// request bundle and the word-range check.
package mem_pkg;

   localparam int unsigned MEM_WORDS_DEF = 128;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mreq_t;

   // Full-width compare so high address bits can never alias into the array.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned words);
      return {2'b00, addr[31:2]} < words;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way winner select: round-robin pointer, or fixed port-0 priority with a
// starvation counter that forces port 1 through after MAX_WAIT losses.
module rr_arb2
   import mem_pkg::*;
#(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned MAX_WAIT   = 15
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       gnt
);

   localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

   logic          ptr;
   logic [CW-1:0] wait_cnt;
   logic          gnt_rr, gnt_fp;

   assign gnt_rr = (&req) ? ptr : req[1];
   assign gnt_fp = req[1] && (!req[0] || (wait_cnt >= WAIT_LIM));
   assign gnt    = FIXED_PRIO ? gnt_fp : gnt_rr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr      <= PORT_CPU;
         wait_cnt <= '0;
      end else if (advance) begin
         ptr <= ~gnt;
         // Counts only arbitrations port 1 actually lost while requesting.
         if (gnt)
            wait_cnt <= '0;
         else if (req[1] && (wait_cnt < WAIT_LIM))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the
// debug/loader (port 1): IDLE -> ACCESS -> RESP, one memory cycle per grant.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS  = MEM_WORDS_DEF,
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned MAX_WAIT   = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic        mwr,
   output logic        moe,
   output logic [31:0] ma,
   output logic [31:0] mwd,
   input  logic [31:0] mrd,
   output logic        busy
);

   state_t state;
   logic   owner, gnt, advance, sel_ok, err_q;
   mreq_t  sel;

   assign advance = (state == IDLE) && (req0 || req1);
   assign busy    = (state != IDLE);

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO),
      .MAX_WAIT   (MAX_WAIT)
   ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     ({req1, req0}),
      .advance (advance),
      .gnt     (gnt)
   );

   always_comb begin
      sel = '{we: we0, addr: addr0, wdata: wdata0};
      if (gnt == PORT_DBG)
         sel = '{we: we1, addr: addr1, wdata: wdata1};
   end

   assign sel_ok = addr_ok(sel.addr, MEM_WORDS);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         owner  <= PORT_CPU;
         err_q  <= 1'b0;
         mwr    <= 1'b0;
         moe    <= 1'b0;
         ma     <= '0;
         mwd    <= '0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (advance) begin
                  // ma/mwd double as the latched request; strobes are
                  // pre-decoded so ACCESS is a pure one-cycle memory op.
                  owner <= gnt;
                  err_q <= !sel_ok;
                  mwr   <= sel.we && sel_ok;
                  moe   <= !sel.we && sel_ok;
                  ma    <= sel.addr;
                  mwd   <= sel.wdata;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               mwr <= 1'b0;
               moe <= 1'b0;
               if (owner == PORT_DBG) begin
                  ack1   <= 1'b1;
                  err1   <= err_q;
                  rdata1 <= moe ? mrd : '0;
               end else begin
                  ack0   <= 1'b1;
                  err0   <= err_q;
                  rdata0 <= moe ? mrd : '0;
               end
               state <= RESP;
            end
            RESP: begin
               ack0   <= 1'b0;
               ack1   <= 1'b0;
               err0   <= 1'b0;
               err1   <= 1'b0;
               rdata0 <= '0;
               rdata1 <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance with a word memory and a
// fixed-priority instance (MAX_WAIT=3) with an address-derived read source.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int unsigned WORDS = 128;
   localparam logic [31:0] FP_KEY = 32'hA5A5_0000;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic        ack0, ack1, err0, err1, mwr, moe, busy;
   logic [31:0] rdata0, rdata1, ma, mwd, mrd;

   logic        req0f = 0, req1f = 0;
   logic [31:0] addr0f = 0, addr1f = 0;
   logic        ack0f, ack1f, err0f, err1f, mwr_f, moe_f, busy_f;
   logic [31:0] rdata0f, rdata1f, ma_f, mwd_f, mrd_f;

   logic [31:0] mem [WORDS];
   logic [31:0] ref_mem [WORDS];
   logic        mem_load = 1'b1;

   int checks = 0;
   int errors = 0;
   bit exp_ptr = 1'b0;

   mem_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1), .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd),
      .mrd(mrd), .busy(busy)
   );

   mem_arbiter #(.FIXED_PRIO(1'b1), .MAX_WAIT(3)) dut_fp (
      .clock(clock), .reset_n(reset_n),
      .req0(req0f), .req1(req1f), .we0(1'b0), .we1(1'b0),
      .addr0(addr0f), .addr1(addr1f), .wdata0(32'h0), .wdata1(32'h0),
      .ack0(ack0f), .ack1(ack1f), .rdata0(rdata0f), .rdata1(rdata1f),
      .err0(err0f), .err1(err1f), .mwr(mwr_f), .moe(moe_f), .ma(ma_f), .mwd(mwd_f),
      .mrd(mrd_f), .busy(busy_f)
   );

   assign mrd   = moe ? mem[ma[8:2]] : 32'h0;
   assign mrd_f = moe_f ? (ma_f ^ FP_KEY) : 32'h0;

   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= ref_mem[i];
      end else if (mwr) begin
         mem[ma[8:2]] <= mwd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
      else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
   endtask

   // One isolated access; called at a negedge with the DUT idle.
   task automatic single(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
      bit          ok;
      logic [31:0] exp_rd;
      ok = (a >> 2) < WORDS;
      exp_rd = (!w && ok) ? ref_mem[a[8:2]] : 32'h0;
      drive(p, 1'b1, w, a, d);
      @(negedge clock);
      chk("access_busy", busy, 1);
      chk("access_mwr", mwr, w && ok);
      chk("access_moe", moe, !w && ok);
      chk("access_ma", ma, a);
      if (w) chk("access_mwd", mwd, d);
      chk("early_ack", {ack1, ack0}, 0);
      drive(p, 1'b1, 1'($urandom), $urandom, $urandom);
      @(negedge clock);
      chk("resp_ack", p ? ack1 : ack0, 1);
      chk("resp_other_ack", p ? ack0 : ack1, 0);
      chk("resp_err", p ? err1 : err0, !ok);
      if (!w) chk("resp_rdata", p ? rdata1 : rdata0, exp_rd);
      chk("resp_other_rdata", p ? rdata0 : rdata1, 0);
      chk("resp_strobes", {mwr, moe}, 0);
      if (w && ok) ref_mem[a[8:2]] = d;
      exp_ptr = !p;
      drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      chk("idle_ack", {ack1, ack0}, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      bit          p, w, win;
      logic [31:0] a, d, a0, a1, d0;
      int          losses;

      for (int i = 0; i < WORDS; i++) ref_mem[i] = $urandom;
      repeat (2) @(negedge clock);
      chk("rst_ack", {ack1, ack0, ack1f, ack0f}, 0);
      chk("rst_err", {err1, err0}, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_strobes", {mwr, moe}, 0);
      chk("rst_ma", ma, 0);
      chk("rst_mwd", mwd, 0);
      chk("rst_busy", busy, 0);
      mem_load = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);

      // Directed write/read at 0x10, then out-of-range on port 1.
      single(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      single(1'b0, 1'b0, 32'h10, 32'h0);
      single(1'b1, 1'b0, 32'h200, 32'h0);
      single(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
      single(1'b1, 1'b0, 32'h1FC, 32'h0);

      // Reset during the ACCESS cycle of a write: no pulse, no ack, no update.
      drive(1'b0, 1'b1, 1'b1, 32'h14, 32'hCAFEF00D);
      @(negedge clock);
      chk("pre_rst_mwr", mwr, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_mwr", mwr, 0);
      chk("rst_mid_busy", busy, 0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) begin
         @(negedge clock);
         chk("rst_hold_ack", {ack1, ack0}, 0);
         chk("rst_hold_mwr", mwr, 0);
      end
      reset_n = 1'b1;
      exp_ptr = 1'b0;
      @(negedge clock);
      single(1'b0, 1'b0, 32'h14, 32'h0);

      // Round-robin contention, pointer freshly back at port 0 after a reset.
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      exp_ptr = 1'b0;
      @(negedge clock);
      a0 = 32'h40; d0 = $urandom; a1 = 32'h84;
      drive(1'b0, 1'b1, 1'b1, a0, d0);
      drive(1'b1, 1'b1, 1'b0, a1, 32'h0);
      for (int k = 0; k < 4; k++) begin
         win = exp_ptr;
         exp_ptr = !win;
         @(negedge clock);
         chk("rr_ma", ma, win ? a1 : a0);
         chk("rr_mwr", mwr, !win);
         @(negedge clock);
         chk("rr_ack0", ack0, !win);
         chk("rr_ack1", ack1, win);
         if (win) chk("rr_rdata1", rdata1, ref_mem[a1[8:2]]);
         else     ref_mem[a0[8:2]] = d0;
         @(negedge clock);
         chk("rr_no_double_ack", {ack1, ack0}, 0);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);

      // Randomized isolated accesses, mostly in range.
      for (int k = 0; k < 24; k++) begin
         p = 1'($urandom);
         w = 1'($urandom);
         d = $urandom;
         if ($urandom_range(0, 5) == 0) a = $urandom;
         else a = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
         single(p, w, a, d);
      end
      single(1'b0, 1'b0, 32'h40, 32'h0);

      // Fixed priority with starvation guard: port 1 wins after 3 losses.
      losses = 0;
      addr0f = 32'h20; addr1f = 32'h30;
      req0f = 1'b1; req1f = 1'b1;
      for (int k = 0; k < 8; k++) begin
         win = (losses >= 3);
         if (win) losses = 0;
         else     losses++;
         @(negedge clock);
         @(negedge clock);
         chk("fp_ack0", ack0f, !win);
         chk("fp_ack1", ack1f, win);
         chk("fp_rdata", win ? rdata1f : rdata0f, (win ? addr1f : addr0f) ^ FP_KEY);
         @(negedge clock);
      end
      req0f = 1'b0; req1f = 1'b0;
      @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
